// File: rtl/ama_riscv_hazard_sequencer.sv
// ama_riscv_hazard_sequencer
//   Central hazard/stall sequencer for the 5-stage core. It does three jobs:
//   - inserts one bubble for load-use hazards that EX->ID forwarding cannot cover;
//   - freezes the whole pipe while a load in MEM waits for slow data memory;
//   - holds the IF-ID flush for several cycles after a taken branch or jump,
//     so that the instruction memory latency drains.
//   It also keeps saturating performance counters.
//
// Ports
//   clk, rst_n                 core clock; asynchronous active-low reset
//   rs1_id/rs2_id, *_used_id   source registers of the instruction in ID
//   rd_ex, reg_we_ex, load_ex  destination/type of the instruction in EX
//   load_mem, dmem_ready       load in MEM waiting for data / data valid
//   redirect_ex                taken branch/jump resolved in EX
//   stall_if/id/ex/mem         hold PC, IF-ID, ID-EX, EX-MEM registers
//   bubble_ex, bubble_wb       load NOP into ID-EX / MEM-WB
//   flush_if, flush_id         squash IF-ID / ID-EX content
//   mem_timeout                sticky: memory wait exceeded MEM_TIMEOUT cycles
//   hz_state                   0 RUN, 1 MEM_WAIT, 2 FLUSH
//   stall_cnt, flush_cnt       stall_if cycles / accepted redirects (saturating)

module ama_riscv_hazard_sequencer #(
    parameter int RF_AW       = 5,
    parameter int FLUSH_CYC   = 2,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RF_AW-1:0] rs1_id,
    input  logic [RF_AW-1:0] rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic [RF_AW-1:0] rd_ex,
    input  logic             reg_we_ex,
    input  logic             load_ex,
    input  logic             load_mem,
    input  logic             dmem_ready,
    input  logic             redirect_ex,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             bubble_ex,
    output logic             bubble_wb,
    output logic             flush_if,
    output logic             flush_id,
    output logic             mem_timeout,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } hz_state_e;

    localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYC - 1);
    localparam logic [WW-1:0] WAIT_MAX   = WW'(MEM_TIMEOUT);

    hz_state_e        state_q,       state_d;
    logic [FW-1:0]    flush_rem_q,   flush_rem_d;   // flush cycles still owed
    logic [WW-1:0]    wait_cnt_q,    wait_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] stall_cnt_q,   stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q,   flush_cnt_d;

    logic      memstall;
    logic      load_use;
    hz_state_e eval_state;

    // Ungated control decisions; gated with rst_n at the ports.
    logic stall_if_c, stall_id_c, stall_ex_c, stall_mem_c;
    logic bubble_ex_c, bubble_wb_c, flush_if_c, flush_id_c;

    assign memstall = load_mem & ~dmem_ready;

    assign load_use = load_ex & reg_we_ex & (rd_ex != '0) &
                      ((rs1_used_id & (rs1_id == rd_ex)) |
                       (rs2_used_id & (rs2_id == rd_ex)));

    // When the memory wait releases, the pipe advances in that same cycle, so
    // the cycle is judged as the state being resumed (FLUSH if flush cycles are
    // still owed, else RUN). This keeps a redirect held in EX from being lost.
    always_comb begin
        eval_state = state_q;
        if (state_q == ST_MEM_WAIT) begin
            eval_state = (flush_rem_q != '0) ? ST_FLUSH : ST_RUN;
        end
    end

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before this edge, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            flush_rem_q   <= '0;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            flush_rem_q   <= flush_rem_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    // ---------------- next state ----------------
    // NOTE: every signal gets a default at the top of the block, so no path
    // leaves one unassigned and no latch can be inferred.
    always_comb begin
        state_d       = state_q;
        flush_rem_d   = flush_rem_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        flush_cnt_d   = flush_cnt_q;

        if (memstall) begin
            // Remaining flush count is kept so FLUSH resumes after the wait.
            state_d = ST_MEM_WAIT;
            if (wait_cnt_q != WAIT_MAX) begin
                wait_cnt_d = wait_cnt_q + WW'(1);
            end
            if (wait_cnt_d == WAIT_MAX) begin
                mem_timeout_d = 1'b1;
            end
        end else begin
            wait_cnt_d = '0;
            if (redirect_ex) begin
                flush_rem_d = FLUSH_LOAD;
                state_d     = (FLUSH_CYC > 1) ? ST_FLUSH : ST_RUN;
                if (flush_cnt_q != '1) begin
                    flush_cnt_d = flush_cnt_q + CNT_W'(1);
                end
            end else if (eval_state == ST_FLUSH) begin
                flush_rem_d = flush_rem_q - FW'(1);
                state_d     = (flush_rem_q == FW'(1)) ? ST_RUN : ST_FLUSH;
            end else begin
                state_d = ST_RUN;
            end
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_if_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // ---------------- outputs (Mealy) ----------------
    always_comb begin
        stall_if_c  = 1'b0;
        stall_id_c  = 1'b0;
        stall_ex_c  = 1'b0;
        stall_mem_c = 1'b0;
        bubble_ex_c = 1'b0;
        bubble_wb_c = 1'b0;
        flush_if_c  = 1'b0;
        flush_id_c  = 1'b0;

        if (memstall) begin
            // Whole pipe frozen; MEM-WB gets a NOP so WB does not repeat.
            stall_if_c  = 1'b1;
            stall_id_c  = 1'b1;
            stall_ex_c  = 1'b1;
            stall_mem_c = 1'b1;
            bubble_wb_c = 1'b1;
        end else if (redirect_ex) begin
            flush_if_c = 1'b1;
            flush_id_c = 1'b1;
        end else if (eval_state == ST_FLUSH) begin
            // ID holds a squashed op here, so load-use is not looked at.
            flush_if_c = 1'b1;
        end else if (load_use) begin
            // One bubble suffices: next cycle the load is in MEM and
            // MEM->EX forwarding supplies the data.
            stall_if_c  = 1'b1;
            stall_id_c  = 1'b1;
            bubble_ex_c = 1'b1;
        end
    end

    // Reset forces every control output low immediately, mid-cycle included.
    assign stall_if  = stall_if_c  & rst_n;
    assign stall_id  = stall_id_c  & rst_n;
    assign stall_ex  = stall_ex_c  & rst_n;
    assign stall_mem = stall_mem_c & rst_n;
    assign bubble_ex = bubble_ex_c & rst_n;
    assign bubble_wb = bubble_wb_c & rst_n;
    assign flush_if  = flush_if_c  & rst_n;
    assign flush_id  = flush_id_c  & rst_n;

    assign mem_timeout = mem_timeout_q;
    assign hz_state    = state_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_ama_riscv_hazard_sequencer.sv
// tb_ama_riscv_hazard_sequencer
//   Directed bench for the hazard sequencer with default parameters
//   (FLUSH_CYC=2, MEM_TIMEOUT=64). Inputs change on the falling edge and
//   outputs are sampled 1 ns later, well away from the rising edge.

module tb_ama_riscv_hazard_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rs1_id, rs2_id, rd_ex;
    logic        rs1_used_id, rs2_used_id, reg_we_ex, load_ex;
    logic        load_mem, dmem_ready, redirect_ex;
    logic        stall_if, stall_id, stall_ex, stall_mem;
    logic        bubble_ex, bubble_wb, flush_if, flush_id;
    logic        mem_timeout;
    logic [1:0]  hz_state;
    logic [31:0] stall_cnt, flush_cnt;

    int n_total = 0;
    int n_bad   = 0;

    // Control outputs packed: {stall_if,stall_id,stall_ex,stall_mem,
    //                          bubble_ex,bubble_wb,flush_if,flush_id}
    logic [7:0] ctl;
    assign ctl = {stall_if, stall_id, stall_ex, stall_mem,
                  bubble_ex, bubble_wb, flush_if, flush_id};

    localparam logic [7:0] C_NONE   = 8'b0000_0000;
    localparam logic [7:0] C_LU     = 8'b1100_1000;
    localparam logic [7:0] C_FREEZE = 8'b1111_0100;
    localparam logic [7:0] C_FL2    = 8'b0000_0011;
    localparam logic [7:0] C_FL1    = 8'b0000_0010;

    ama_riscv_hazard_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs1_id      (rs1_id),
        .rs2_id      (rs2_id),
        .rs1_used_id (rs1_used_id),
        .rs2_used_id (rs2_used_id),
        .rd_ex       (rd_ex),
        .reg_we_ex   (reg_we_ex),
        .load_ex     (load_ex),
        .load_mem    (load_mem),
        .dmem_ready  (dmem_ready),
        .redirect_ex (redirect_ex),
        .stall_if    (stall_if),
        .stall_id    (stall_id),
        .stall_ex    (stall_ex),
        .stall_mem   (stall_mem),
        .bubble_ex   (bubble_ex),
        .bubble_wb   (bubble_wb),
        .flush_if    (flush_if),
        .flush_id    (flush_id),
        .mem_timeout (mem_timeout),
        .hz_state    (hz_state),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0;
        rs1_used_id = 1'b0; rs2_used_id = 1'b0;
        reg_we_ex = 1'b0; load_ex = 1'b0;
        load_mem = 1'b0; dmem_ready = 1'b0; redirect_ex = 1'b0;
    endtask

    // Advance to the next falling edge with all inputs idle.
    task automatic nxt();
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic load_use_x5();
        load_ex = 1'b1; reg_we_ex = 1'b1; rd_ex = 5'd5;
        rs1_id = 5'd5; rs1_used_id = 1'b1;
    endtask

    task automatic memstall_in();
        load_mem = 1'b1; dmem_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        // ---- reset state, hazard inputs present while in reset ----
        load_use_x5();
        memstall_in();
        #2;
        check("rst_ctl", 32'(ctl), 32'(C_NONE));
        check("rst_state", 32'(hz_state), 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        check("rst_timeout", 32'(mem_timeout), 0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        // ---- 1: load-use ----
        nxt(); load_use_x5(); #1;
        check("lu_stall", 32'(ctl), 32'(C_LU));
        check("lu_state", 32'(hz_state), 0);
        nxt(); load_mem = 1'b1; dmem_ready = 1'b1; rs1_id = 5'd5; rs1_used_id = 1'b1; #1;
        check("lu_after", 32'(ctl), 32'(C_NONE));
        nxt(); load_use_x5(); rd_ex = 5'd0; rs1_id = 5'd0; #1;
        check("lu_x0", 32'(ctl), 32'(C_NONE));
        nxt(); load_use_x5(); rs1_used_id = 1'b0; #1;
        check("lu_rs1_unused", 32'(ctl), 32'(C_NONE));
        nxt(); load_use_x5(); rs1_used_id = 1'b0; rs2_id = 5'd5; rs2_used_id = 1'b1; #1;
        check("lu_rs2", 32'(ctl), 32'(C_LU));
        nxt(); load_use_x5(); reg_we_ex = 1'b0; #1;
        check("lu_no_we", 32'(ctl), 32'(C_NONE));
        check("lu_stall_cnt", stall_cnt, 2);

        // ---- 2: memory stall for 3 cycles ----
        do_reset();
        for (int i = 0; i < 3; i++) begin
            nxt(); memstall_in(); #1;
            check("ms_ctl", 32'(ctl), 32'(C_FREEZE));
            check("ms_state", 32'(hz_state), (i == 0) ? 0 : 1);
        end
        nxt(); load_mem = 1'b1; dmem_ready = 1'b1; #1;
        check("ms_ready_ctl", 32'(ctl), 32'(C_NONE));
        check("ms_stall_cnt", stall_cnt, 3);
        nxt(); #1;
        check("ms_back_run", 32'(hz_state), 0);
        check("ms_stall_cnt2", stall_cnt, 3);

        // ---- 3: redirect, FLUSH_CYC=2; load-use during FLUSH ignored ----
        do_reset();
        nxt(); redirect_ex = 1'b1; #1;
        check("rd_c0_ctl", 32'(ctl), 32'(C_FL2));
        check("rd_c0_state", 32'(hz_state), 0);
        nxt(); load_use_x5(); #1;
        check("rd_c1_ctl", 32'(ctl), 32'(C_FL1));
        check("rd_c1_state", 32'(hz_state), 2);
        check("rd_flush_cnt", flush_cnt, 1);
        nxt(); #1;
        check("rd_c2_ctl", 32'(ctl), 32'(C_NONE));
        check("rd_c2_state", 32'(hz_state), 0);
        check("rd_stall_cnt", stall_cnt, 0);

        // ---- 4a: redirect together with memstall -> freeze only ----
        do_reset();
        nxt(); redirect_ex = 1'b1; memstall_in(); #1;
        check("rm_c0_ctl", 32'(ctl), 32'(C_FREEZE));
        nxt(); redirect_ex = 1'b1; memstall_in(); #1;
        check("rm_c1_ctl", 32'(ctl), 32'(C_FREEZE));
        check("rm_c1_state", 32'(hz_state), 1);
        check("rm_c1_fcnt", flush_cnt, 0);
        nxt(); redirect_ex = 1'b1; load_mem = 1'b1; dmem_ready = 1'b1; #1;
        check("rm_ready_ctl", 32'(ctl), 32'(C_FL2));
        nxt(); #1;
        check("rm_c3_ctl", 32'(ctl), 32'(C_FL1));
        check("rm_c3_state", 32'(hz_state), 2);
        check("rm_c3_fcnt", flush_cnt, 1);
        nxt(); #1;
        check("rm_c4_state", 32'(hz_state), 0);

        // ---- 4b: memstall inside FLUSH keeps the owed flush cycle ----
        nxt(); redirect_ex = 1'b1; #1;
        check("fm_c0_ctl", 32'(ctl), 32'(C_FL2));
        nxt(); memstall_in(); #1;
        check("fm_c1_ctl", 32'(ctl), 32'(C_FREEZE));
        check("fm_c1_state", 32'(hz_state), 2);
        nxt(); load_mem = 1'b1; dmem_ready = 1'b1; #1;
        check("fm_ready_ctl", 32'(ctl), 32'(C_FL1));
        check("fm_ready_state", 32'(hz_state), 1);
        nxt(); #1;
        check("fm_end_ctl", 32'(ctl), 32'(C_NONE));
        check("fm_end_state", 32'(hz_state), 0);
        check("fm_flush_cnt", flush_cnt, 2);

        // ---- 5: timeout after 64 wait cycles, sticky ----
        do_reset();
        for (int i = 0; i < 63; i++) begin
            nxt(); memstall_in();
        end
        nxt(); memstall_in(); #1;
        check("to_before", 32'(mem_timeout), 0);
        check("to_ctl", 32'(ctl), 32'(C_FREEZE));
        nxt(); load_mem = 1'b1; dmem_ready = 1'b1; #1;
        check("to_set", 32'(mem_timeout), 1);
        check("to_ready_ctl", 32'(ctl), 32'(C_NONE));
        check("to_stall_cnt", stall_cnt, 64);
        nxt(); #1;
        check("to_sticky", 32'(mem_timeout), 1);
        check("to_state", 32'(hz_state), 0);

        // ---- 6: async reset in the middle of MEM_WAIT ----
        nxt(); memstall_in();
        nxt(); memstall_in(); #1;
        check("ar_pre_ctl", 32'(ctl), 32'(C_FREEZE));
        check("ar_pre_state", 32'(hz_state), 1);
        #1 rst_n = 1'b0;
        #1;
        check("ar_ctl", 32'(ctl), 32'(C_NONE));
        check("ar_state", 32'(hz_state), 0);
        check("ar_stall_cnt", stall_cnt, 0);
        check("ar_flush_cnt", flush_cnt, 0);
        check("ar_timeout", 32'(mem_timeout), 0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        nxt(); #1;
        check("ar_after_state", 32'(hz_state), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
